ama_riscv_bp_gshare: RTL and testbench
======================================

Name: ama_riscv_bp_gshare

Overview:
Branch direction predictor feeding the front-end controller's speculative path. It supplies the bp_pred direction and the predicted-taken target for the branch currently in decode. The table is a gshare table of 2-bit saturating counters; setting GHR_BITS=0 degenerates it to bimodal. The table and the global history are trained non-speculatively when the branch resolves in execute.

Parameters:
IDX_BITS, 5, log2 of counter-table entries (32 entries).
GHR_BITS, 5, global history length; 0 = pure bimodal; must be <= IDX_BITS.

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
pred_req  input  1  branch in decode requesting a prediction (same as spec.enter)
pc_dec  input  32  PC of the instruction in decode
imm_b_dec  input  32  sign-extended B-type immediate of the decode instruction
bp_pred  output  branch_t  predicted direction (B_T/B_NT)
bp_target  output  32  pc_dec + imm_b_dec, valid when bp_pred==B_T
upd_valid  input  1  branch resolved in execute this cycle (spec.resolve)
upd_pc  input  32  PC of the resolving branch (pc_cp)
upd_res  input  branch_t  actual outcome (branch_resolution)
upd_hit  input  1  prediction was correct (bp_hit)
ghr  output  GHR_BITS (min 1)  current global history, for debug
cnt_pred  output  32  number of predictions issued
cnt_miss  output  32  number of mispredictions

Behaviour:
- Index: idx(pc) = pc[IDX_BITS+1:2] XOR zero-extended ghr. With GHR_BITS=0, idx(pc) = pc[IDX_BITS+1:2].
- Lookup is combinational, zero latency. bp_pred = B_T iff counter[idx(pc_dec)][1]==1. bp_target = pc_dec + imm_b_dec, computed mod 2^32 with wrap-around allowed.
- bp_pred and bp_target are driven whenever pred_req is low, but consumers ignore them then.
- Counter update happens on the posedge where upd_valid=1:
  - taken: counter = min(counter+1, 3).
  - not taken: counter = max(counter-1, 0).
  - Saturation at 3 (strong T) and 0 (strong NT) is mandatory; no wrap.
- Update index uses the ghr value present in the same cycle, before its shift. This is valid because at most one prediction is outstanding, so the ghr is unchanged between predict and resolve.
- GHR shift happens on the same edge: ghr = {ghr[GHR_BITS-2:0], upd_res==B_T}. With GHR_BITS=1, ghr = upd_res==B_T.
- Simultaneous pred_req and upd_valid:
  - the lookup uses the pre-update counter and pre-shift ghr (read-before-write, no bypass);
  - the new state is visible the next cycle.
- Counters:
  - cnt_pred increments on each cycle with pred_req=1.
  - cnt_miss increments when upd_valid=1 and upd_hit=0.
  - Both saturate at 0xFFFF_FFFF.
- upd_valid with upd_pc=0 is treated as a normal update. Filtering is the controller's job.
- Reset values:
  - all counters = 2'b01 (weak NT), so bp_pred = B_NT on the first lookup;
  - ghr = 0;
  - cnt_pred = cnt_miss = 0.
- Reset is a single-cycle full clear. Reset asserted together with upd_valid means reset wins and no update is applied.
- No state machine beyond per-entry 2-bit FSMs: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- Implementation: table held in flops (IDX_BITS <= 6); no SRAM.

Test Plan:
- Reset then pred_req with pc_dec=0x100, imm_b_dec=0x20 -> bp_pred=B_NT, bp_target=0x120, cnt_pred=1 after the edge.
- GHR_BITS=0, three upd_valid cycles on upd_pc=0x100 with upd_res=B_T, then a fourth -> counter sequence 01→10→11→11 (saturated); lookup of 0x100 gives B_T.
- GHR_BITS=5, upd B_T on pc 0x104 with ghr=0 -> entry idx 1 becomes 10, ghr=00001. A subsequent lookup of 0x104 reads idx 1^1=0, still 01 → B_NT.
- Same-cycle pred_req and upd_valid on pc 0x200 (counter 01, upd B_T) -> bp_pred=B_NT that cycle, B_T the next cycle.
- Two upd_valid with upd_hit=0 and one with upd_hit=1 -> cnt_miss=2. pc_dec=0xFFFF_FFF0 with imm_b_dec=0x20 -> bp_target=0x0000_0010.
- Train several entries, then assert rst for 1 cycle in the same cycle as an upd_valid -> all lookups return B_NT, ghr=0, both counters 0.

Source files
------------

// File: rtl/ama_riscv_bp_gshare.sv
// Gshare branch direction predictor: a table of 2-bit saturating counters indexed by
// PC XOR global history. It is trained when the branch resolves in execute.
package ama_riscv_bp_gshare_pkg;
    typedef enum logic {
        B_NT = 1'b0,
        B_T  = 1'b1
    } branch_t;
endpackage

module ama_riscv_bp_gshare
    import ama_riscv_bp_gshare_pkg::*;
#(
    parameter int IDX_BITS = 5,
    parameter int GHR_BITS = 5,
    localparam int GHR_W   = (GHR_BITS == 0) ? 1 : GHR_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pred_req,
    input  logic [31:0]       pc_dec,
    input  logic [31:0]       imm_b_dec,
    output branch_t           bp_pred,
    output logic [31:0]       bp_target,
    input  logic              upd_valid,
    input  logic [31:0]       upd_pc,
    input  branch_t           upd_res,
    input  logic              upd_hit,
    output logic [GHR_W-1:0]  ghr,
    output logic [31:0]       cnt_pred,
    output logic [31:0]       cnt_miss
);
    localparam int ENTRIES = 1 << IDX_BITS;

    logic [1:0]          tbl_q [ENTRIES];
    logic [1:0]          tbl_d [ENTRIES];
    logic [GHR_W-1:0]    ghr_q, ghr_d;
    logic [31:0]         cnt_pred_q, cnt_pred_d;
    logic [31:0]         cnt_miss_q, cnt_miss_d;
    logic [IDX_BITS-1:0] ghr_idx;
    logic [IDX_BITS-1:0] pred_idx;
    logic [IDX_BITS-1:0] upd_idx;
    logic                upd_taken;

    // Only the index bits of the resolving PC take part in the lookup.
    logic unused_upd_pc;
    assign unused_upd_pc = ^{upd_pc[31:IDX_BITS+2], upd_pc[1:0]};

    assign upd_taken = (upd_res == B_T);

    generate
        if (GHR_BITS == 0) begin : g_bimodal
            assign ghr_idx = '0;
            always_comb ghr_d = '0;
        end else if (GHR_BITS == 1) begin : g_ghr1
            assign ghr_idx = IDX_BITS'(ghr_q);
            always_comb begin
                ghr_d = ghr_q;
                if (upd_valid) ghr_d = upd_taken;
            end
        end else begin : g_ghrn
            assign ghr_idx = IDX_BITS'(ghr_q);
            always_comb begin
                ghr_d = ghr_q;
                if (upd_valid) ghr_d = {ghr_q[GHR_W-2:0], upd_taken};
            end
        end
    endgenerate

    // Both indices use the pre-shift history: only one prediction is ever in flight.
    assign pred_idx  = pc_dec[IDX_BITS+1:2] ^ ghr_idx;
    assign upd_idx   = upd_pc[IDX_BITS+1:2] ^ ghr_idx;
    assign bp_pred   = tbl_q[pred_idx][1] ? B_T : B_NT;
    assign bp_target = pc_dec + imm_b_dec;

    always_comb begin
        tbl_d = tbl_q;
        if (upd_valid) begin
            if (upd_taken && (tbl_q[upd_idx] != 2'b11))
                tbl_d[upd_idx] = tbl_q[upd_idx] + 2'b01;
            else if (!upd_taken && (tbl_q[upd_idx] != 2'b00))
                tbl_d[upd_idx] = tbl_q[upd_idx] - 2'b01;
        end
    end

    always_comb begin
        cnt_pred_d = cnt_pred_q;
        cnt_miss_d = cnt_miss_q;
        if (pred_req && (cnt_pred_q != '1))
            cnt_pred_d = cnt_pred_q + 32'd1;
        if (upd_valid && !upd_hit && (cnt_miss_q != '1))
            cnt_miss_d = cnt_miss_q + 32'd1;
    end

    // NOTE: the table lives in flops, so resetting every entry is legal and cheap;
    // a RAM-backed table could not be cleared in a single cycle like this.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= 2'b01;
            ghr_q      <= '0;
            cnt_pred_q <= '0;
            cnt_miss_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every read in this cycle on old state.
            tbl_q      <= tbl_d;
            ghr_q      <= ghr_d;
            cnt_pred_q <= cnt_pred_d;
            cnt_miss_q <= cnt_miss_d;
        end
    end

    assign ghr      = ghr_q;
    assign cnt_pred = cnt_pred_q;
    assign cnt_miss = cnt_miss_q;

endmodule

// File: tb/tb_ama_riscv_bp_gshare.sv
// Directed table-driven bench: one bimodal (GHR_BITS=0) and one gshare (GHR_BITS=5)
// instance share the same stimulus and are compared against hand-computed values.
module tb_ama_riscv_bp_gshare;
    import ama_riscv_bp_gshare_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        pred_req;
    logic [31:0] pc_dec;
    logic [31:0] imm_b_dec;
    logic        upd_valid;
    logic [31:0] upd_pc;
    branch_t     upd_res;
    logic        upd_hit;

    branch_t     bm_pred, gs_pred;
    logic [31:0] bm_tgt, gs_tgt;
    logic [0:0]  bm_ghr;
    logic [4:0]  gs_ghr;
    logic [31:0] bm_cp, bm_cm, gs_cp, gs_cm;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ama_riscv_bp_gshare #(.IDX_BITS(5), .GHR_BITS(0)) u_bm (
        .clk(clk), .rst(rst), .pred_req(pred_req), .pc_dec(pc_dec), .imm_b_dec(imm_b_dec),
        .bp_pred(bm_pred), .bp_target(bm_tgt), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_res(upd_res), .upd_hit(upd_hit), .ghr(bm_ghr), .cnt_pred(bm_cp), .cnt_miss(bm_cm)
    );

    ama_riscv_bp_gshare #(.IDX_BITS(5), .GHR_BITS(5)) u_gs (
        .clk(clk), .rst(rst), .pred_req(pred_req), .pc_dec(pc_dec), .imm_b_dec(imm_b_dec),
        .bp_pred(gs_pred), .bp_target(gs_tgt), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_res(upd_res), .upd_hit(upd_hit), .ghr(gs_ghr), .cnt_pred(gs_cp), .cnt_miss(gs_cm)
    );

    typedef struct {
        logic        rst;
        logic        req;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        uv;
        logic [31:0] upc;
        branch_t     ures;
        logic        uhit;
        branch_t     exp_bm;
        branch_t     exp_gs;
        logic [31:0] exp_tgt;
        logic [4:0]  exp_ghr;
        logic [31:0] exp_cp;
        logic [31:0] exp_cm;
    } vec_t;

    vec_t vecs [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst       = v.rst;
        pred_req  = v.req;
        pc_dec    = v.pc;
        imm_b_dec = v.imm;
        upd_valid = v.uv;
        upd_pc    = v.upc;
        upd_res   = v.ures;
        upd_hit   = v.uhit;
    endtask

    initial begin
        // Expected pre-edge lookups and post-edge state, derived by hand step by step.
        //            rst   req   pc            imm       uv    upc       res   hit   bm    gs    tgt           ghr    cp  cm
        vecs[0]  = '{1'b0, 1'b1, 32'h100,      32'h20, 1'b0, 32'h0,   B_NT, 1'b0, B_NT, B_NT, 32'h120,      5'h00, 1,  0};
        vecs[1]  = '{1'b0, 1'b0, 32'h100,      32'h20, 1'b1, 32'h100, B_T,  1'b1, B_NT, B_NT, 32'h120,      5'h01, 1,  0};
        vecs[2]  = '{1'b0, 1'b0, 32'h100,      32'h20, 1'b1, 32'h100, B_T,  1'b0, B_T,  B_NT, 32'h120,      5'h03, 1,  1};
        vecs[3]  = '{1'b0, 1'b0, 32'h100,      32'h20, 1'b1, 32'h100, B_T,  1'b0, B_T,  B_NT, 32'h120,      5'h07, 1,  2};
        vecs[4]  = '{1'b0, 1'b1, 32'h100,      32'h20, 1'b1, 32'h100, B_T,  1'b1, B_T,  B_NT, 32'h120,      5'h0F, 2,  2};
        vecs[5]  = '{1'b0, 1'b1, 32'h100,      32'h20, 1'b0, 32'h0,   B_NT, 1'b0, B_T,  B_NT, 32'h120,      5'h0F, 3,  2};
        vecs[6]  = '{1'b0, 1'b0, 32'h108,      32'h20, 1'b1, 32'h108, B_NT, 1'b1, B_NT, B_NT, 32'h128,      5'h1E, 3,  2};
        vecs[7]  = '{1'b0, 1'b0, 32'h108,      32'h20, 1'b1, 32'h108, B_NT, 1'b1, B_NT, B_NT, 32'h128,      5'h1C, 3,  2};
        vecs[8]  = '{1'b0, 1'b0, 32'h108,      32'h20, 1'b1, 32'h108, B_T,  1'b0, B_NT, B_NT, 32'h128,      5'h19, 3,  3};
        vecs[9]  = '{1'b0, 1'b1, 32'h108,      32'h20, 1'b0, 32'h0,   B_NT, 1'b0, B_NT, B_NT, 32'h128,      5'h19, 4,  3};
        vecs[10] = '{1'b1, 1'b1, 32'h100,      32'h20, 1'b1, 32'h100, B_T,  1'b0, B_T,  B_NT, 32'h120,      5'h00, 0,  0};
        vecs[11] = '{1'b0, 1'b1, 32'h100,      32'h20, 1'b0, 32'h0,   B_NT, 1'b0, B_NT, B_NT, 32'h120,      5'h00, 1,  0};
        vecs[12] = '{1'b0, 1'b1, 32'hFFFF_FFF0, 32'h20, 1'b0, 32'h0,   B_NT, 1'b0, B_NT, B_NT, 32'h0000_0010, 5'h00, 2,  0};
        vecs[13] = '{1'b0, 1'b0, 32'h104,      32'h20, 1'b1, 32'h104, B_T,  1'b1, B_NT, B_NT, 32'h124,      5'h01, 2,  0};
        vecs[14] = '{1'b0, 1'b1, 32'h104,      32'h20, 1'b0, 32'h0,   B_NT, 1'b0, B_T,  B_NT, 32'h124,      5'h01, 3,  0};
        vecs[15] = '{1'b0, 1'b1, 32'h208,      32'h40, 1'b1, 32'h208, B_T,  1'b1, B_NT, B_NT, 32'h248,      5'h03, 4,  0};
        vecs[16] = '{1'b0, 1'b1, 32'h208,      32'h40, 1'b0, 32'h0,   B_NT, 1'b0, B_T,  B_T,  32'h248,      5'h03, 5,  0};
        vecs[17] = '{1'b0, 1'b0, 32'h0,        32'h0,  1'b1, 32'h0,   B_NT, 1'b0, B_NT, B_T,  32'h0,        5'h06, 5,  1};
        vecs[18] = '{1'b0, 1'b1, 32'h0,        32'h0,  1'b0, 32'h0,   B_NT, 1'b0, B_NT, B_NT, 32'h0,        5'h06, 6,  1};

        // Reset sequence and reset-state checks.
        rst = 1'b1; pred_req = 1'b0; pc_dec = 32'h0; imm_b_dec = 32'h0;
        upd_valid = 1'b0; upd_pc = 32'h0; upd_res = B_NT; upd_hit = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_bm_pred", 32'(bm_pred), 32'(B_NT));
        check("reset_gs_pred", 32'(gs_pred), 32'(B_NT));
        check("reset_gs_ghr",  32'(gs_ghr), 32'h0);
        check("reset_cnt_pred", gs_cp, 32'h0);
        check("reset_cnt_miss", gs_cm, 32'h0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check($sformatf("v%0d_bm_pred", i), 32'(bm_pred), 32'(vecs[i].exp_bm));
            check($sformatf("v%0d_gs_pred", i), 32'(gs_pred), 32'(vecs[i].exp_gs));
            check($sformatf("v%0d_target", i), gs_tgt, vecs[i].exp_tgt);
            check($sformatf("v%0d_bm_target", i), bm_tgt, vecs[i].exp_tgt);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_gs_ghr", i), 32'(gs_ghr), 32'(vecs[i].exp_ghr));
            check($sformatf("v%0d_bm_ghr", i), 32'(bm_ghr), 32'h0);
            check($sformatf("v%0d_bm_cnt_pred", i), bm_cp, vecs[i].exp_cp);
            check($sformatf("v%0d_gs_cnt_pred", i), gs_cp, vecs[i].exp_cp);
            check($sformatf("v%0d_bm_cnt_miss", i), bm_cm, vecs[i].exp_cm);
            check($sformatf("v%0d_gs_cnt_miss", i), gs_cm, vecs[i].exp_cm);
        end

        // Idle cycle: nothing requested or resolved, so all state must hold.
        @(negedge clk);
        pred_req = 1'b0; upd_valid = 1'b0; rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_gs_ghr", 32'(gs_ghr), 32'h06);
        check("idle_cnt_pred", gs_cp, 32'd6);
        check("idle_cnt_miss", bm_cm, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
